// File: rtl/sseg_pkg.sv
// ---------------------------------------------------------------------------
// sseg_pkg
// Shared definitions for the multiplexed-to-static seven-segment capture:
//   - BLANK_ACTIVE_LOW / BLANK_ACTIVE_HIGH : "all segments off" patterns
//   - sel_class_e / sel_info_t            : digit-select classification result
//   - classify()                          : NONE / ONE / MULTI plus one-hot index
//   - clog2()                             : elaboration-time ceil(log2)
// ---------------------------------------------------------------------------
package sseg_pkg;

  localparam logic [6:0] BLANK_ACTIVE_LOW  = 7'h7F;
  localparam logic [6:0] BLANK_ACTIVE_HIGH = 7'h00;

  // Widest select bus classify() accepts; callers zero-extend narrower buses.
  localparam int MAX_DIGITS = 32;
  localparam int MAX_IDX_W  = 5;

  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_class_e;

  typedef struct packed {
    sel_class_e             cls;
    logic [MAX_IDX_W-1:0]   idx;  // meaningful only when cls == SEL_ONE
  } sel_info_t;

  // Ceiling log2; clog2(0) and clog2(1) both return 0.
  function automatic int clog2(input longint unsigned value);
    int              bits;
    longint unsigned span;
    bits = 0;
    span = 1;
    while (span < value) begin
      span = span << 1;
      bits++;
    end
    return bits;
  endfunction

  // Counts active select bits; idx ends up as the position of the last set
  // bit, which is the one-hot index when exactly one bit is set.
  function automatic sel_info_t classify(input logic [MAX_DIGITS-1:0] sel);
    sel_info_t info;
    int        active;
    info.cls = SEL_NONE;
    info.idx = '0;
    active   = 0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (sel[i]) begin
        active++;
        info.idx = MAX_IDX_W'(i);
      end
    end
    if (active == 1) begin
      info.cls = SEL_ONE;
    end else if (active > 1) begin
      info.cls = SEL_MULTI;
    end
    return info;
  endfunction

endpackage

// File: rtl/sseg_digit_slot.sv
// ---------------------------------------------------------------------------
// sseg_digit_slot
// One static digit: segment register, valid flag and stale-digit timeout.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : timeout counting runs only while high
//   i_capture      : load i_data, mark valid, restart the timeout
//   i_hold         : digit is still being driven statically; keep timeout at 0
//   i_data         : segment value to capture
//   o_seg, o_valid : registered segment image and valid flag
// ---------------------------------------------------------------------------
module sseg_digit_slot
  import sseg_pkg::*;
#(
  parameter int               SEG_W   = 7,
  parameter int               TIMEOUT = 1048576,
  parameter logic [SEG_W-1:0] BLANK   = SEG_W'(BLANK_ACTIVE_LOW),
  parameter int               CNT_W   = 21
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_capture,
  input  logic             i_hold,
  input  logic [SEG_W-1:0] i_data,
  output logic [SEG_W-1:0] o_seg,
  output logic             o_valid
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT != 0);

  logic [SEG_W-1:0] r_seg;
  logic             r_valid;
  logic [CNT_W-1:0] r_to_cnt;
  logic [CNT_W-1:0] w_to_inc;

  assign w_to_inc = r_to_cnt + CNT_W'(1);

  // NOTE: reset is sampled inside the clocked block, so it is synchronous and
  // has priority over every other branch below.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_seg    <= BLANK;
      r_valid  <= 1'b0;
      r_to_cnt <= '0;
    end else if (i_capture) begin
      // Capture outranks an expiry that would land on the same edge.
      r_seg    <= i_data;
      r_valid  <= 1'b1;
      r_to_cnt <= '0;
    end else if (i_hold) begin
      r_to_cnt <= '0;
    end else if (TO_EN && i_enable && (r_to_cnt != TO_LIMIT)) begin
      // Counter saturates at the limit, so the blanking fires once.
      r_to_cnt <= w_to_inc;
      if (w_to_inc == TO_LIMIT) begin
        r_seg   <= BLANK;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_seg   = r_seg;
  assign o_valid = r_valid;

endmodule

// File: rtl/sseg_scan_capture.sv
// ---------------------------------------------------------------------------
// sseg_scan_capture
// Samples a time-multiplexed anode/segment bus and holds a registered static
// image per digit. A digit is captured only after its select and segment
// pattern have been stable for SETTLE consecutive registered samples, which
// rejects ghosting during digit transitions.
//   OSCCLK      : system clock
//   reset       : synchronous, active-high
//   enable      : 1 = capture and timeout counting run, 0 = both freeze
//   an_in       : digit-select bus (polarity set by AN_ACTIVE_LOW)
//   sseg_in     : shared segment bus
//   seg_out     : digit i at [i*SEG_W +: SEG_W]
//   digit_valid : digit holds a captured, unexpired value
//   collision   : one-cycle pulse per sample with more than one digit selected
// ---------------------------------------------------------------------------
module sseg_scan_capture
  import sseg_pkg::*;
#(
  parameter int               DIGITS        = 4,
  parameter int               SEG_W         = 7,
  parameter bit               AN_ACTIVE_LOW = 1'b1,
  parameter int               SETTLE        = 4,
  parameter int               TIMEOUT       = 1048576,
  parameter logic [SEG_W-1:0] BLANK         = SEG_W'(BLANK_ACTIVE_LOW)
) (
  input  logic                      OSCCLK,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [DIGITS-1:0]         an_in,
  input  logic [SEG_W-1:0]          sseg_in,
  output logic [DIGITS*SEG_W-1:0]   seg_out,
  output logic [DIGITS-1:0]         digit_valid,
  output logic                      collision
);

  localparam int                IDX_W     = (DIGITS > 1) ? clog2(DIGITS) : 1;
  localparam int                TO_W      = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;
  localparam logic [7:0]        SETTLE_C  = 8'(SETTLE);
  localparam logic [DIGITS-1:0] AN_IDLE   = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : '0;

  // Stage-1 input registers and the previous classified sample.
  logic [DIGITS-1:0] r_an_q;
  logic [SEG_W-1:0]  r_seg_q;
  logic [DIGITS-1:0] r_prev_sel;
  logic [SEG_W-1:0]  r_prev_seg;
  logic [7:0]        r_stab_cnt;
  logic              r_run_done;   // current stable run has already captured
  logic              r_collision;

  logic [DIGITS-1:0] w_sel;
  sel_info_t         w_info;
  logic              w_one;
  logic              w_multi;
  logic              w_same;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_stab_nxt;
  logic              w_hold;
  logic              w_capture;
  logic              w_run_done_nxt;
  logic [DIGITS-1:0] w_cap_vec;
  logic [DIGITS-1:0] w_hold_vec;

  always_ff @(posedge OSCCLK) begin
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    if (reset) begin
      r_an_q      <= AN_IDLE;
      r_seg_q     <= BLANK;
      r_prev_sel  <= '0;
      r_prev_seg  <= BLANK;
      r_stab_cnt  <= '0;
      r_run_done  <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      r_an_q      <= an_in;
      r_seg_q     <= sseg_in;
      r_prev_sel  <= w_sel;
      r_prev_seg  <= r_seg_q;
      r_stab_cnt  <= w_stab_nxt;
      r_run_done  <= w_run_done_nxt;
      r_collision <= w_multi;
    end
  end

  always_comb begin
    // NOTE: every signal gets a value on every path (defaults first), so no
    // latch can be inferred.
    w_sel      = AN_ACTIVE_LOW ? ~r_an_q : r_an_q;
    w_info     = classify(MAX_DIGITS'(w_sel));
    w_one      = (w_info.cls == SEL_ONE);
    w_multi    = (w_info.cls == SEL_MULTI);
    w_idx      = w_info.idx[IDX_W-1:0];
    w_same     = (w_sel == r_prev_sel) && (r_seg_q == r_prev_seg);
    w_stab_nxt = '0;

    // None/multi clear the count; a new pattern starts a run at 1.
    if (w_one) begin
      if (!w_same) begin
        w_stab_nxt = 8'd1;
      end else if (r_stab_cnt >= SETTLE_C) begin
        w_stab_nxt = SETTLE_C;
      end else begin
        w_stab_nxt = r_stab_cnt + 8'd1;
      end
    end

    // A captured run that keeps going only refreshes the digit's timeout.
    // A run that saturated while disabled captures as soon as enable returns.
    w_hold         = w_one && w_same && r_run_done;
    w_capture      = enable && w_one && (w_stab_nxt == SETTLE_C) && !w_hold;
    w_run_done_nxt = w_capture || w_hold;
  end

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_slot
    assign w_cap_vec[gi]  = w_capture && (w_idx == IDX_W'(gi));
    assign w_hold_vec[gi] = w_hold    && (w_idx == IDX_W'(gi));

    sseg_digit_slot #(
      .SEG_W   (SEG_W),
      .TIMEOUT (TIMEOUT),
      .BLANK   (BLANK),
      .CNT_W   (TO_W)
    ) u_slot (
      .i_clk     (OSCCLK),
      .i_reset   (reset),
      .i_enable  (enable),
      .i_capture (w_cap_vec[gi]),
      .i_hold    (w_hold_vec[gi]),
      .i_data    (r_seg_q),
      .o_seg     (seg_out[gi*SEG_W +: SEG_W]),
      .o_valid   (digit_valid[gi])
    );
  end

  assign collision = r_collision;

endmodule
